jtvigil_objrom_slot: RTL and testbench

JTVIGIL_OBJROM_SLOT -- requirements
Module: jtvigil_objrom_slot

---
 rtl/jtvigil_pkg.sv | 20 ++
 rtl/jtvigil_objrom_slot.sv | 99 +++++++++
 tb/tb_jtvigil_objrom_slot.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/jtvigil_pkg.sv
// Shared types for the jtvigil object ROM path.
// Holds the fetch FSM encoding and the SDRAM address helper.
package jtvigil_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_LO   = 2'd2,
        ST_HI   = 2'd3
    } objrom_st_t;

    // 32-bit word index -> 16-bit word address, wrapping at 22 bits
    function automatic logic [21:0] obj_sdram_addr(
        input logic [21:0] base,
        input logic [17:0] waddr
    );
        return base + {3'b000, waddr, 1'b0};
    endfunction

endpackage

// File: rtl/jtvigil_objrom_slot.sv
// One-entry cached slot between the object engine and the SDRAM controller.
// A miss fetches two 16-bit words (low then high) into a 32-bit line.
module jtvigil_objrom_slot
    import jtvigil_pkg::*;
#(
    parameter logic [21:0] OFFSET = 22'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rom_cs,
    input  logic [17:0] rom_addr,
    output logic [31:0] rom_data,
    output logic        rom_ok,
    output logic [21:0] sdram_addr,
    output logic        sdram_req,
    input  logic        sdram_ack,
    input  logic        sdram_dst,
    input  logic [15:0] sdram_din
);

    objrom_st_t  st_q, st_d;
    logic [17:0] tag_q, tag_d;
    logic        valid_q, valid_d;
    logic [31:0] data_q, data_d;
    logic        req_q, req_d;
    logic [21:0] addr_q, addr_d;
    logic        hit;

    assign hit        = valid_q && (tag_q == rom_addr);
    assign rom_ok     = rom_cs && hit;
    assign rom_data   = data_q;
    assign sdram_req  = req_q;
    assign sdram_addr = addr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q    <= ST_IDLE;
            tag_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            req_q   <= 1'b0;
            addr_q  <= OFFSET;
        end else begin
            st_q    <= st_d;
            tag_q   <= tag_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        st_d    = st_q;
        tag_d   = tag_q;
        valid_d = valid_q;
        data_d  = data_q;
        req_d   = req_q;
        addr_d  = addr_q;
        unique case (st_q)
            ST_IDLE: begin
                if (rom_cs && !hit) begin
                    tag_d   = rom_addr;
                    valid_d = 1'b0;
                    addr_d  = obj_sdram_addr(OFFSET, rom_addr);
                    req_d   = 1'b1;
                    st_d    = ST_REQ;
                end
            end
            ST_REQ: begin
                if (sdram_ack) begin
                    req_d = 1'b0;
                    // controller may strobe the first word with the ack
                    if (sdram_dst) begin
                        data_d[15:0] = sdram_din;
                        st_d         = ST_HI;
                    end else begin
                        st_d = ST_LO;
                    end
                end
            end
            ST_LO: begin
                if (sdram_dst) begin
                    data_d[15:0] = sdram_din;
                    st_d         = ST_HI;
                end
            end
            ST_HI: begin
                if (sdram_dst) begin
                    data_d[31:16] = sdram_din;
                    valid_d       = 1'b1;
                    st_d          = ST_IDLE;
                end
            end
            default: st_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_jtvigil_objrom_slot.sv
// Directed bench for jtvigil_objrom_slot with an SDRAM responder.
// Expected addresses/lines are queued at request time and popped on completion.
module tb_jtvigil_objrom_slot;

    localparam logic [21:0] OFS = 22'h10000;

    logic        clk = 1'b0;
    logic        rst;
    logic        rom_cs;
    logic [17:0] rom_addr;
    logic [31:0] rom_data;
    logic        rom_ok;
    logic [21:0] sdram_addr;
    logic        sdram_req;
    logic        sdram_ack;
    logic        sdram_dst;
    logic [15:0] sdram_din;

    int errors = 0;
    int checks = 0;
    int req_count = 0;
    int cnt0;
    logic req_prev = 1'b0;
    logic [21:0] cur_addr;
    logic [21:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];

    jtvigil_objrom_slot #(.OFFSET(OFS)) dut (
        .clk        (clk),
        .rst        (rst),
        .rom_cs     (rom_cs),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .rom_ok     (rom_ok),
        .sdram_addr (sdram_addr),
        .sdram_req  (sdram_req),
        .sdram_ack  (sdram_ack),
        .sdram_dst  (sdram_dst),
        .sdram_din  (sdram_din)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        req_prev <= sdram_req;
        if (sdram_req && !req_prev) req_count <= req_count + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [21:0] a, input logic [31:0] d);
        exp_addr_q.push_back(a);
        exp_data_q.push_back(d);
    endtask

    // wait for the request, hold ack low wait_n cycles, then ack
    task automatic serve_req(input int wait_n, input bit same);
        int n = 0;
        while (!sdram_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!sdram_req) chk("req_timeout", 32'd0, 32'd1);
        cur_addr = exp_addr_q.pop_front();
        chk("sdram_addr", {10'd0, sdram_addr}, {10'd0, cur_addr});
        repeat (wait_n) begin
            @(negedge clk);
            chk("req_hold", {31'd0, sdram_req}, 32'd1);
        end
        sdram_ack = 1'b1;
        if (same) begin
            sdram_dst = 1'b1;
            sdram_din = exp_data_q[0][15:0];
        end
        @(negedge clk);
        sdram_ack = 1'b0;
        sdram_dst = 1'b0;
        chk("req_drop", {31'd0, sdram_req}, 32'd0);
    endtask

    task automatic serve_data(input bit same);
        logic [31:0] d;
        d = exp_data_q.pop_front();
        if (!same) begin
            sdram_dst = 1'b1;
            sdram_din = d[15:0];
            @(negedge clk);
        end
        sdram_dst = 1'b1;
        sdram_din = d[31:16];
        chk("addr_stable", {10'd0, sdram_addr}, {10'd0, cur_addr});
        @(negedge clk);
        sdram_dst = 1'b0;
        chk("rom_data", rom_data, d);
    endtask

    initial begin
        rst       = 1'b1;
        rom_cs    = 1'b0;
        rom_addr  = '0;
        sdram_ack = 1'b0;
        sdram_dst = 1'b0;
        sdram_din = '0;
        repeat (2) @(negedge clk);
        chk("rst_ok", {31'd0, rom_ok}, 32'd0);
        chk("rst_req", {31'd0, sdram_req}, 32'd0);
        chk("rst_addr", {10'd0, sdram_addr}, {10'd0, OFS});
        chk("rst_data", rom_data, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Test 1: basic miss with 2-cycle ack wait
        rom_cs   = 1'b1;
        rom_addr = 18'h00123;
        push(22'h10246, 32'hDEADBEEF);
        #1 chk("t1_miss_ok", {31'd0, rom_ok}, 32'd0);
        serve_req(2, 1'b0);
        serve_data(1'b0);
        chk("t1_ok", {31'd0, rom_ok}, 32'd1);
        chk("t1_addr", {10'd0, sdram_addr}, 32'h00010246);

        // Test 2: toggle address away and back
        @(negedge clk);
        cnt0     = req_count;
        rom_addr = 18'h00122;
        push(22'h10244, 32'h11112222);
        #1 chk("t2_ok_122", {31'd0, rom_ok}, 32'd0);
        serve_req(1, 1'b0);
        serve_data(1'b0);
        chk("t2_ok_122_done", {31'd0, rom_ok}, 32'd1);
        chk("t2_reqs_1", req_count, cnt0 + 1);
        rom_addr = 18'h00123;
        push(22'h10246, 32'hCAFEF00D);
        #1 chk("t2_ok_123", {31'd0, rom_ok}, 32'd0);
        serve_req(0, 1'b0);
        serve_data(1'b0);
        chk("t2_ok_123_done", {31'd0, rom_ok}, 32'd1);
        chk("t2_reqs_2", req_count, cnt0 + 2);

        // Test 3: address moves while in LO
        @(negedge clk);
        rom_addr = 18'h00050;
        push(22'h100A0, 32'h50505050);
        serve_req(0, 1'b0);
        rom_addr = 18'h00051;
        push(22'h100A2, 32'h51515151);
        serve_data(1'b0);
        chk("t3_ok_stale", {31'd0, rom_ok}, 32'd0);
        serve_req(0, 1'b0);
        serve_data(1'b0);
        chk("t3_ok_new", {31'd0, rom_ok}, 32'd1);

        // Test 4: held hit issues no traffic
        repeat (20) begin
            @(negedge clk);
            chk("t4_ok", {31'd0, rom_ok}, 32'd1);
            chk("t4_req", {31'd0, sdram_req}, 32'd0);
        end

        // Test 5: reset during HI, then a stray strobe
        rom_addr = 18'h00200;
        push(22'h10400, 32'h5555AAAA);
        serve_req(0, 1'b0);
        sdram_dst = 1'b1;
        sdram_din = 16'hAAAA;
        @(negedge clk);
        sdram_dst = 1'b0;
        rst       = 1'b1;
        #1;
        chk("t5_rst_ok", {31'd0, rom_ok}, 32'd0);
        chk("t5_rst_req", {31'd0, sdram_req}, 32'd0);
        chk("t5_rst_addr", {10'd0, sdram_addr}, {10'd0, OFS});
        chk("t5_rst_data", rom_data, 32'd0);
        void'(exp_data_q.pop_front());
        rom_cs = 1'b0;
        @(negedge clk);
        rst       = 1'b0;
        sdram_dst = 1'b1;
        sdram_din = 16'h1234;
        @(negedge clk);
        sdram_dst = 1'b0;
        @(negedge clk);
        chk("t5_stray_data", rom_data, 32'd0);
        chk("t5_stray_req", {31'd0, sdram_req}, 32'd0);
        rom_addr = 18'h00000;
        rom_cs   = 1'b1;
        push(22'h10000, 32'h87654321);
        #1 chk("t5_valid_clr", {31'd0, rom_ok}, 32'd0);

        // Test 6: first strobe in the ack cycle
        serve_req(0, 1'b1);
        serve_data(1'b1);
        chk("t6_ok", {31'd0, rom_ok}, 32'd1);
        chk("t6_q_empty", exp_data_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
